// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder: STAGES chunks with a registered carry between them and valid/ready flow control.
// Optional subtract mode (port i_sub) is enabled by defining PIPELINED_ADDER_SUB_EN.
module pipelined_adder #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_valid,
   output logic             i_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
`ifdef PIPELINED_ADDER_SUB_EN
   input  logic             i_sub,
`endif
   output logic             o_valid,
   input  logic             o_ready,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout
);

   localparam int CHUNK = WIDTH / STAGES;

   // Bits above chunk k; operand bits at or below it are already consumed.
   function automatic logic [WIDTH-1:0] upper_mask(input int k);
      logic [WIDTH-1:0] m;
      for (int i = 0; i < WIDTH; i++) begin
         m[i] = (i >= (k + 1) * CHUNK);
      end
      return m;
   endfunction

   logic             sub0;
   logic             advance;

   logic [WIDTH-1:0] a_q   [STAGES];
   logic [WIDTH-1:0] b_q   [STAGES];
   logic [WIDTH-1:0] s_q   [STAGES];
   logic             c_q   [STAGES];
   logic             v_q   [STAGES];
   logic             sub_q [STAGES];

   logic [WIDTH-1:0] a_in   [STAGES];
   logic [WIDTH-1:0] b_in   [STAGES];
   logic [WIDTH-1:0] s_in   [STAGES];
   logic             c_in   [STAGES];
   logic             v_in   [STAGES];
   logic             sub_in [STAGES];

   logic [CHUNK:0]   part [STAGES];
   logic [WIDTH-1:0] a_d  [STAGES];
   logic [WIDTH-1:0] b_d  [STAGES];
   logic [WIDTH-1:0] s_d  [STAGES];

`ifdef PIPELINED_ADDER_SUB_EN
   assign sub0 = i_sub;
`else
   assign sub0 = 1'b0;
`endif

   // The whole pipe moves together or not at all, so bubbles are never squeezed out.
   assign advance = !o_valid || o_ready;
   assign i_ready = advance;

   always_comb begin
      a_in[0]   = i_a;
      b_in[0]   = i_b;
      s_in[0]   = '0;
      c_in[0]   = sub0 | i_cin;
      v_in[0]   = i_valid;
      sub_in[0] = sub0;
      for (int k = 1; k < STAGES; k++) begin
         a_in[k]   = a_q[k-1];
         b_in[k]   = b_q[k-1];
         s_in[k]   = s_q[k-1];
         c_in[k]   = c_q[k-1];
         v_in[k]   = v_q[k-1];
         sub_in[k] = sub_q[k-1];
      end
   end

   // Stage k adds its own chunk, keeps finished lower sum chunks and forwards the still-unused operand chunks.
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         part[k] = {1'b0, a_in[k][k*CHUNK +: CHUNK]}
                 + {1'b0, b_in[k][k*CHUNK +: CHUNK] ^ {CHUNK{sub_in[k]}}}
                 + {{CHUNK{1'b0}}, c_in[k]};
         s_d[k] = s_in[k];
         s_d[k][k*CHUNK +: CHUNK] = part[k][CHUNK-1:0];
         a_d[k] = a_in[k] & upper_mask(k);
         b_d[k] = b_in[k] & upper_mask(k);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            s_q[k]   <= '0;
            c_q[k]   <= 1'b0;
            v_q[k]   <= 1'b0;
            sub_q[k] <= 1'b0;
         end
      end else if (advance) begin
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]   <= a_d[k];
            b_q[k]   <= b_d[k];
            s_q[k]   <= s_d[k];
            c_q[k]   <= part[k][CHUNK];
            v_q[k]   <= v_in[k];
            sub_q[k] <= sub_in[k];
         end
      end
   end

   assign o_valid = v_q[STAGES-1];
   assign o_sum   = s_q[STAGES-1];
   assign o_cout  = c_q[STAGES-1];

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined successor to the combinational ripple adder.
- Splits a WIDTH-bit addition into STAGES carry-registered chunks so wide sums close timing at mesh router clock rates.
- Used for counters, timestamp and credit arithmetic in the mesh.
- Valid/ready handshake on both sides, full-pipeline stall on backpressure.

Parameters:
- WIDTH, 32: operand and sum width in bits; must be divisible by STAGES.
- STAGES, 4: number of pipeline stages; CHUNK = WIDTH/STAGES bits added per stage. 1 <= STAGES <= WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- i_valid  input  1  operands present
- i_ready  output  1  block accepts operands this cycle
- i_a  input  WIDTH  operand A
- i_b  input  WIDTH  operand B
- i_cin  input  1  carry in
- o_valid  output  1  result present
- o_ready  input  1  downstream accepts result
- o_sum  output  WIDTH  sum, registered
- o_cout  output  1  carry out of bit WIDTH-1, registered

Behaviour:
- Reset:
  - rst_n low clears all stage valid bits, o_valid=0, o_sum=0, o_cout=0, and all internal carry, operand and partial-sum registers.
  - Reset acts asynchronously; release is synchronous to clk.
  - Reset mid-operation discards all in-flight results; no partial result is ever presented.
- Datapath:
  - Stage k (0..STAGES-1) adds chunk k of A and B (bits k*CHUNK .. k*CHUNK+CHUNK-1) plus the carry registered by stage k-1.
  - Stage 0 uses i_cin.
  - Upper operand chunks travel skewed: they are delayed in registers until their stage.
  - Lower sum chunks travel deskewed: they are delayed until the final stage.
  - o_sum equals (A + B + cin) mod 2^WIDTH; o_cout equals bit WIDTH of the full sum.
- Latency:
  - Exactly STAGES cycles from an accepted input (i_valid & i_ready at edge t) to o_valid high after edge t+STAGES-1, i.e. visible in cycle t+STAGES, absent stalls.
  - STAGES=1 gives a single registered adder.
- Handshake:
  - advance = !o_valid | o_ready; i_ready = advance. i_ready is combinational from o_valid/o_ready only, never from i_valid.
  - On advance, every stage register and valid bit shifts one stage; stage 0 loads input and valid = i_valid.
  - When advance is 0, all registers hold, including bubbles.
- Throughput: one result per cycle when o_ready is held high.
- Stall rules:
  - o_sum/o_cout are stable while o_valid=1 and o_ready=0.
  - Bubbles are not compressed: a stall freezes the whole pipe.
- Simultaneous events: i_valid & i_ready in the same cycle as o_valid & o_ready shifts both in one edge; no result is lost or duplicated.
- Ordering: results leave strictly in acceptance order.

Optional Feature:
- Macro PIPELINED_ADDER_SUB_EN.
- When defined:
  - Adds input port i_sub (1 bit, sampled with operands).
  - When i_sub=1, stage logic uses ~B and forces stage-0 carry-in to 1, ignoring i_cin. Result is A-B mod 2^WIDTH; o_cout=1 means no borrow.
  - i_sub is pipelined alongside the operands, so mixed add/sub streams are legal back-to-back.
- When not defined: no i_sub port; behaviour is add only, as above.

Test Plan:
- WIDTH=32, STAGES=4, o_ready=1. Accept A=0xFFFFFFFF, B=0x00000001, cin=0 at cycle 0 -> cycle 4: o_valid=1, o_sum=0x00000000, o_cout=1 (carry crosses all 4 stages).
- Stream A=n, B=0x10000000*n, cin=n[0] for n=0..15 on consecutive cycles -> 16 consecutive valid results in order, each equal to the reference sum. No gaps.
- Backpressure: o_ready low for 5 cycles while the pipe is full with A=0x12345678, B=0x0F0F0F0F -> o_sum held at 0x21436587, i_ready=0; release -> remaining results drain in order, none dropped or duplicated.
- Reset mid-flight: assert rst_n low asynchronously, mid-cycle, with 3 results in flight -> o_valid, o_sum, o_cout go 0 immediately. After release with no inputs, o_valid stays 0 for 8 cycles.
- STAGES=1 and STAGES=32 (WIDTH=32), A=0x80000000, B=0x80000000, cin=1 -> o_sum=0x00000001, o_cout=1 after 1 and 32 cycles respectively.
- With PIPELINED_ADDER_SUB_EN: alternate i_sub=1 (A=5, B=7) and i_sub=0 (A=5, B=7) -> results in order: 0xFFFFFFFE with cout=0, then 0x0000000C with cout=0.
